// File: rtl/reg_scoreboard_ctrl_if.sv
// Decode/issue/retire handshake bundle for the register scoreboard.
// The master side is the pipeline (decode, EXU, WBU). The slave side is the scoreboard.
interface reg_scoreboard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CSR_W = 3
);
  logic             dec_valid;
  logic [REG_W-1:0] dec_rs1;
  logic             dec_rs1_used;
  logic [REG_W-1:0] dec_rs2;
  logic             dec_rs2_used;
  logic [REG_W-1:0] dec_rd;
  logic             dec_rd_write;
  logic [CSR_W-1:0] dec_csr_rd;
  logic             dec_csr_read;
  logic [CSR_W-1:0] dec_csr_wr;
  logic             dec_csr_write;
  logic             exu_ready;
  logic             dec_ready;
  logic             issue_valid;
  logic             ret_valid;
  logic [REG_W-1:0] ret_rd;
  logic             ret_rd_write;
  logic [CSR_W-1:0] ret_csr;
  logic             ret_csr_write;

  modport master (
    output dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
           dec_rd, dec_rd_write, dec_csr_rd, dec_csr_read, dec_csr_wr,
           dec_csr_write, exu_ready, ret_valid, ret_rd, ret_rd_write,
           ret_csr, ret_csr_write,
    input  dec_ready, issue_valid
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
           dec_rd, dec_rd_write, dec_csr_rd, dec_csr_read, dec_csr_wr,
           dec_csr_write, exu_ready, ret_valid, ret_rd, ret_rd_write,
           ret_csr, ret_csr_write,
    output dec_ready, issue_valid
  );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Register/CSR hazard scoreboard between decode and EXU issue.
// Each GPR and CSR slot has a pending-write counter. Issue raises the counter and WBU retire lowers it.
// Decode is held while any source is still pending, or while the in-flight cap is reached.
module reg_scoreboard_ctrl #(
  parameter int  NREGS        = 32,
  parameter int  REG_W        = 5,
  parameter int  NCSR         = 8,
  parameter int  CSR_W        = 3,
  parameter int  CNT_W        = 2,
  parameter int  MAX_INFLIGHT = 3,
  localparam int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_scoreboard_ctrl_if.slave sb,
  input  logic                 flush,
  output logic                 stall_raw,
  output logic [INF_W-1:0]     inflight,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREGS-1:0][CNT_W-1:0] gpr_cnt, gpr_nxt;
  logic [NCSR-1:0][CNT_W-1:0]  csr_cnt, csr_nxt;
  logic [INF_W-1:0]            inflight_nxt;
  logic [CNT_W:0]              cnt_step;
  logic                        underflow_evt;
  logic                        h1, h2, hc, full, block, fire;

  // One counter update: the top bit of the result flags a decrement attempted at zero.
  function automatic logic [CNT_W:0] step_cnt(input logic [CNT_W-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CNT_W:0] res;
    res = {1'b0, cnt};
    if (inc && !dec && (cnt != CNT_MAX))
      res = {1'b0, cnt + CNT_W'(1)};
    else if (dec && !inc)
      res = (cnt == '0) ? {1'b1, cnt} : {1'b0, cnt - CNT_W'(1)};
    return res;
  endfunction

  // Hazards look only at registered counters, so a retire in this cycle does not release a stall yet.
  always_comb begin
    h1    = sb.dec_rs1_used && (sb.dec_rs1 != '0) && (gpr_cnt[sb.dec_rs1] != '0);
    h2    = sb.dec_rs2_used && (sb.dec_rs2 != '0) && (gpr_cnt[sb.dec_rs2] != '0);
    hc    = sb.dec_csr_read && (csr_cnt[sb.dec_csr_rd] != '0);
    full  = (inflight == INF_W'(MAX_INFLIGHT));
    stall_raw      = sb.dec_valid & (h1 | h2 | hc);
    block          = stall_raw | full;
    sb.dec_ready   = sb.exu_ready & ~block;
    sb.issue_valid = sb.dec_valid & sb.exu_ready & ~block & ~flush;
    fire           = sb.issue_valid;
  end

  // x0 is never tracked, so its busy bit is tied low.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NREGS; i++)
      busy_vec[i] = (gpr_cnt[i] != '0);
  end

  // Next-state counters and in-flight count. A flush wipes everything and ignores this cycle's retire.
  always_comb begin
    gpr_nxt       = gpr_cnt;
    csr_nxt       = csr_cnt;
    inflight_nxt  = inflight;
    underflow_evt = 1'b0;
    cnt_step      = '0;
    for (int i = 1; i < NREGS; i++) begin
      cnt_step = step_cnt(gpr_cnt[i],
                          fire && sb.dec_rd_write && (sb.dec_rd == REG_W'(i)),
                          sb.ret_valid && sb.ret_rd_write && (sb.ret_rd == REG_W'(i)));
      gpr_nxt[i]    = cnt_step[CNT_W-1:0];
      underflow_evt = underflow_evt | cnt_step[CNT_W];
    end
    for (int j = 0; j < NCSR; j++) begin
      cnt_step = step_cnt(csr_cnt[j],
                          fire && sb.dec_csr_write && (sb.dec_csr_wr == CSR_W'(j)),
                          sb.ret_valid && sb.ret_csr_write && (sb.ret_csr == CSR_W'(j)));
      csr_nxt[j]    = cnt_step[CNT_W-1:0];
      underflow_evt = underflow_evt | cnt_step[CNT_W];
    end
    case ({fire, sb.ret_valid})
      2'b10: if (!full) inflight_nxt = inflight + INF_W'(1);
      2'b01: begin
        if (inflight == '0) underflow_evt = 1'b1;
        else                inflight_nxt  = inflight - INF_W'(1);
      end
      default: ;
    endcase
    if (flush) begin
      gpr_nxt       = '0;
      csr_nxt       = '0;
      inflight_nxt  = '0;
      underflow_evt = 1'b0;
    end
  end

  // State registers. The underflow flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_cnt       <= '0;
      csr_cnt       <= '0;
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      gpr_cnt       <= gpr_nxt;
      csr_cnt       <= csr_nxt;
      inflight      <= inflight_nxt;
      err_underflow <= err_underflow | underflow_evt;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Directed scoreboard bench for reg_scoreboard_ctrl.
// Each step drives one cycle of inputs and queues the hand-derived outputs for that cycle.
module tb_reg_scoreboard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       dec_valid;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic [4:0] rd;
    logic       rd_write;
    logic [2:0] csr_rd;
    logic       csr_read;
    logic [2:0] csr_wr;
    logic       csr_write;
    logic       exu_ready;
    logic       ret_valid;
    logic [4:0] ret_rd;
    logic       ret_rd_write;
    logic [2:0] ret_csr;
    logic       ret_csr_write;
    logic       flush;
  } stim_t;

  typedef struct packed {
    logic        iv;
    logic        dr;
    logic        sr;
    logic [1:0]  inf;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        stall_raw;
  logic [1:0]  inflight;
  logic [31:0] busy_vec;
  logic        err_underflow;

  int    n_compared = 0;
  int    n_mismatched = 0;
  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;

  reg_scoreboard_ctrl_if #(.REG_W(5), .CSR_W(3)) sb_if ();

  reg_scoreboard_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sb            (sb_if),
    .flush         (flush),
    .stall_raw     (stall_raw),
    .inflight      (inflight),
    .busy_vec      (busy_vec),
    .err_underflow (err_underflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input string tag, input stim_t s, input exp_t e);
    @(negedge clk);
    rst_n                = s.rst_n;
    sb_if.dec_valid      = s.dec_valid;
    sb_if.dec_rs1        = s.rs1;
    sb_if.dec_rs1_used   = s.rs1_used;
    sb_if.dec_rs2        = s.rs2;
    sb_if.dec_rs2_used   = s.rs2_used;
    sb_if.dec_rd         = s.rd;
    sb_if.dec_rd_write   = s.rd_write;
    sb_if.dec_csr_rd     = s.csr_rd;
    sb_if.dec_csr_read   = s.csr_read;
    sb_if.dec_csr_wr     = s.csr_wr;
    sb_if.dec_csr_write  = s.csr_write;
    sb_if.exu_ready      = s.exu_ready;
    sb_if.ret_valid      = s.ret_valid;
    sb_if.ret_rd         = s.ret_rd;
    sb_if.ret_rd_write   = s.ret_rd_write;
    sb_if.ret_csr        = s.ret_csr;
    sb_if.ret_csr_write  = s.ret_csr_write;
    flush                = s.flush;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s           = '0;
    s.rst_n     = 1'b1;
    s.exu_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t wr(input logic [4:0] rd);
    stim_t s;
    s           = idle();
    s.dec_valid = 1'b1;
    s.rd        = rd;
    s.rd_write  = 1'b1;
    return s;
  endfunction

  function automatic stim_t ret(input stim_t s_in, input logic [4:0] rd);
    stim_t s;
    s              = s_in;
    s.ret_valid    = 1'b1;
    s.ret_rd       = rd;
    s.ret_rd_write = 1'b1;
    return s;
  endfunction

  function automatic exp_t ex(input logic iv, input logic dr, input logic sr,
                              input logic [1:0] inf, input logic [31:0] busy, input logic err);
    exp_t e;
    e.iv = iv; e.dr = dr; e.sr = sr; e.inf = inf; e.busy = busy; e.err = err;
    return e;
  endfunction

  // Monitor: samples mid-low-phase, pops the expectation queued for this cycle
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checkOutput({mon_t, ".issue_valid"}, 32'(sb_if.issue_valid), 32'(mon_e.iv));
      checkOutput({mon_t, ".dec_ready"},   32'(sb_if.dec_ready),   32'(mon_e.dr));
      checkOutput({mon_t, ".stall_raw"},   32'(stall_raw),         32'(mon_e.sr));
      checkOutput({mon_t, ".inflight"},    32'(inflight),          32'(mon_e.inf));
      checkOutput({mon_t, ".busy_vec"},    busy_vec,               mon_e.busy);
      checkOutput({mon_t, ".err"},         32'(err_underflow),     32'(mon_e.err));
    end
  end

  initial begin
    stim_t s;
    stim_t dep;
    int    guard;

    // reset state
    s = idle(); s.rst_n = 1'b0;
    applyStimulus("reset", s, ex(0, 1, 0, 0, 32'h0, 0));

    // addi x5, then dependent add x6,x5,x0 stalls until x5 retires
    dep = wr(6); dep.rs1 = 5; dep.rs1_used = 1; dep.rs2 = 0; dep.rs2_used = 1;
    applyStimulus("c0_addi",     wr(5),         ex(1, 1, 0, 0, 32'h0, 0));
    applyStimulus("c1_dep",      dep,           ex(0, 0, 1, 1, 32'h20, 0));
    applyStimulus("c2_dep",      dep,           ex(0, 0, 1, 1, 32'h20, 0));
    applyStimulus("c3_dep_ret",  ret(dep, 5),   ex(0, 0, 1, 1, 32'h20, 0));
    applyStimulus("c4_release",  dep,           ex(1, 1, 0, 0, 32'h0, 0));
    applyStimulus("c5_x6_busy",  idle(),        ex(0, 1, 0, 1, 32'h40, 0));
    applyStimulus("c6_ret_x6",   ret(idle(), 6), ex(0, 1, 0, 1, 32'h40, 0));
    applyStimulus("c7_empty",    idle(),        ex(0, 1, 0, 0, 32'h0, 0));

    // in-flight cap
    dep = wr(4); dep.rs1 = 10; dep.rs1_used = 1;
    applyStimulus("cap_rd1",     wr(1),         ex(1, 1, 0, 0, 32'h0, 0));
    applyStimulus("cap_rd2",     wr(2),         ex(1, 1, 0, 1, 32'h2, 0));
    applyStimulus("cap_rd3",     wr(3),         ex(1, 1, 0, 2, 32'h6, 0));
    applyStimulus("cap_full",    dep,           ex(0, 0, 0, 3, 32'he, 0));
    applyStimulus("cap_full_ret", ret(dep, 1),  ex(0, 0, 0, 3, 32'he, 0));
    applyStimulus("cap_issue4",  dep,           ex(1, 1, 0, 2, 32'hc, 0));
    applyStimulus("cap_ret2",    ret(idle(), 2), ex(0, 0, 0, 3, 32'h1c, 0));
    applyStimulus("cap_ret3",    ret(idle(), 3), ex(0, 1, 0, 2, 32'h18, 0));
    applyStimulus("cap_ret4",    ret(idle(), 4), ex(0, 1, 0, 1, 32'h10, 0));
    applyStimulus("cap_empty",   idle(),        ex(0, 1, 0, 0, 32'h0, 0));

    // same-cycle issue and retire of rd=7
    applyStimulus("same_issue",  wr(7),         ex(1, 1, 0, 0, 32'h0, 0));
    applyStimulus("same_both",   ret(wr(7), 7), ex(1, 1, 0, 1, 32'h80, 0));
    applyStimulus("same_after",  ret(idle(), 7), ex(0, 1, 0, 1, 32'h80, 0));
    applyStimulus("same_empty",  idle(),        ex(0, 1, 0, 0, 32'h0, 0));

    // x0 as destination is never tracked and never stalls a reader
    dep = wr(8); dep.rs1 = 0; dep.rs1_used = 1; dep.rs2 = 0; dep.rs2_used = 1;
    applyStimulus("x0_write",    wr(0),         ex(1, 1, 0, 0, 32'h0, 0));
    applyStimulus("x0_read",     dep,           ex(1, 1, 0, 1, 32'h0, 0));
    applyStimulus("x0_ret",      ret(idle(), 0), ex(0, 1, 0, 2, 32'h100, 0));
    applyStimulus("x0_ret8",     ret(idle(), 8), ex(0, 1, 0, 1, 32'h100, 0));
    applyStimulus("x0_empty",    idle(),        ex(0, 1, 0, 0, 32'h0, 0));

    // CSR slot 2 write in flight blocks a slot-2 read
    s = idle(); s.dec_valid = 1; s.csr_wr = 2; s.csr_write = 1;
    applyStimulus("csr_write",   s,             ex(1, 1, 0, 0, 32'h0, 0));
    dep = wr(9); dep.csr_rd = 2; dep.csr_read = 1;
    applyStimulus("csr_read",    dep,           ex(0, 0, 1, 1, 32'h0, 0));
    s = dep; s.ret_valid = 1; s.ret_csr = 2; s.ret_csr_write = 1;
    applyStimulus("csr_ret",     s,             ex(0, 0, 1, 1, 32'h0, 0));
    applyStimulus("csr_release", dep,           ex(1, 1, 0, 0, 32'h0, 0));
    applyStimulus("csr_ret9",    ret(idle(), 9), ex(0, 1, 0, 1, 32'h200, 0));
    applyStimulus("csr_empty",   idle(),        ex(0, 1, 0, 0, 32'h0, 0));

    // flush with pending state and a concurrent issue/retire
    applyStimulus("fl_rd10",     wr(10),        ex(1, 1, 0, 0, 32'h0, 0));
    applyStimulus("fl_rd11",     wr(11),        ex(1, 1, 0, 1, 32'h400, 0));
    s = ret(wr(12), 10); s.flush = 1;
    applyStimulus("fl_flush",    s,             ex(0, 1, 0, 2, 32'hc00, 0));
    applyStimulus("fl_after",    idle(),        ex(0, 1, 0, 0, 32'h0, 0));

    // retire with nothing in flight sets the sticky error
    s = idle(); s.ret_valid = 1;
    applyStimulus("uf_ret",      s,             ex(0, 1, 0, 0, 32'h0, 0));
    applyStimulus("uf_set",      idle(),        ex(0, 1, 0, 0, 32'h0, 1));
    applyStimulus("uf_rd13",     wr(13),        ex(1, 1, 0, 0, 32'h0, 1));
    s = idle(); s.flush = 1;
    applyStimulus("uf_flush",    s,             ex(0, 1, 0, 1, 32'h2000, 1));
    applyStimulus("uf_kept",     wr(14),        ex(1, 1, 0, 0, 32'h0, 1));

    // async reset mid-operation clears state immediately
    s = idle(); s.rst_n = 1'b0;
    applyStimulus("async_rst",   s,             ex(0, 1, 0, 0, 32'h0, 0));

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      #3;
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
